// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a 4-op ALU (IDLE/EXEC/RESP).
// Optional rsp_carry/rsp_zero outputs are enabled by macro ALU_ARBITER_FLAGS_EN.
module alu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req0_op,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
`ifdef ALU_ARBITER_FLAGS_EN
  output logic             rsp_carry,
  output logic             rsp_zero,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             rid_q, rid_d;
  logic [WIDTH:0]   res;
  logic             any_v;
  logic             gnt;

`ifdef ALU_ARBITER_FLAGS_EN
  logic carry_q, carry_d;
  logic zero_q, zero_d;
`endif

  // ALU on the latched operands; top bit is carry-out or borrow
  always_comb begin
    res = '0;
    case (op_q)
      2'b00:   res = {1'b0, a_q & b_q};
      2'b01:   res = {1'b0, a_q | b_q};
      2'b10:   res = {1'b0, a_q} + {1'b0, b_q};
      default: res = {1'b0, a_q} - {1'b0, b_q};
    endcase
  end

  // Grant choice: pointer breaks ties, a lone requester always wins
  always_comb begin
    any_v = req0_valid | req1_valid;
    gnt   = (req0_valid & req1_valid) ? ptr_q : ~req0_valid;
  end

  // Next-state, datapath capture and handshake outputs
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    id_d       = id_q;
    y_d        = y_q;
    rid_d      = rid_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
`ifdef ALU_ARBITER_FLAGS_EN
    carry_d    = carry_q;
    zero_d     = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_v && rst_n) begin
          req0_ready = ~gnt;
          req1_ready = gnt;
          a_d        = gnt ? req1_a : req0_a;
          b_d        = gnt ? req1_b : req0_b;
          op_d       = gnt ? req1_op : req0_op;
          id_d       = gnt;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        y_d     = res[WIDTH-1:0];
        rid_d   = id_q;
`ifdef ALU_ARBITER_FLAGS_EN
        carry_d = res[WIDTH];
        zero_d  = (res[WIDTH-1:0] == '0);
`endif
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          ptr_d   = ~rid_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      y_q     <= '0;
      rid_q   <= 1'b0;
`ifdef ALU_ARBITER_FLAGS_EN
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      y_q     <= y_d;
      rid_q   <= rid_d;
`ifdef ALU_ARBITER_FLAGS_EN
      carry_q <= carry_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_y     = y_q;
  assign rsp_id    = rid_q;
`ifdef ALU_ARBITER_FLAGS_EN
  assign rsp_carry = carry_q;
  assign rsp_zero  = zero_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a reference model predicts grants
// and results at each falling edge and checks every DUT output.
module tb_alu_arbiter;

  localparam int W = 4;

  typedef struct packed {
    logic         id;
    logic [W-1:0] y;
    logic         c;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req1_valid = 1'b0;
  logic         req0_ready;
  logic         req1_ready;
  logic [W-1:0] req0_a = '0;
  logic [W-1:0] req0_b = '0;
  logic [W-1:0] req1_a = '0;
  logic [W-1:0] req1_b = '0;
  logic [1:0]   req0_op = '0;
  logic [1:0]   req1_op = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic         rsp_id;
  logic [W-1:0] rsp_y;
  logic         busy;
`ifdef ALU_ARBITER_FLAGS_EN
  logic         rsp_carry;
  logic         rsp_zero;
`endif

  alu_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y),
`ifdef ALU_ARBITER_FLAGS_EN
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_alu(input logic id, input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     input logic [1:0] op);
    exp_t e;
    int   ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    e.id = id;
    e.c  = 1'b0;
    case (op)
      2'b00: r = int'(a & b);
      2'b01: r = int'(a | b);
      2'b10: begin r = ai + bi; e.c = (r >= (1 << W)); end
      default: begin r = ai - bi; e.c = (ai < bi); end
    endcase
    e.y = r[W-1:0];
    e.z = (e.y == '0);
    return e;
  endfunction

  exp_t         sbq[$];
  exp_t         e_cur;
  int           mst = 0;
  logic         mptr = 1'b0;
  logic [W-1:0] lasty = '0;
  logic         g;
  logic         vld;
  int           grants = 0;
  int           served = 0;
  logic         seen_id;
  logic [W-1:0] seen_y;
  logic         seen_c;
  logic         seen_z;
  logic         ids[$];

  // Reference model: predicts the FSM and checks outputs each falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      mst   = 0;
      mptr  = 1'b0;
      lasty = '0;
      sbq.delete();
      chk("rst_valid", rsp_valid, 0);
      chk("rst_y", rsp_y, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_rdy0", req0_ready, 0);
      chk("rst_rdy1", req1_ready, 0);
      chk("rst_busy", busy, 0);
`ifdef ALU_ARBITER_FLAGS_EN
      chk("rst_carry", rsp_carry, 0);
      chk("rst_zero", rsp_zero, 0);
`endif
    end else begin
      chk("busy", busy, mst != 0);
      chk("rsp_valid", rsp_valid, mst == 2);
      if (mst == 0) begin
        vld = req0_valid | req1_valid;
        g   = (req0_valid && req1_valid) ? mptr : !req0_valid;
        chk("rdy0", req0_ready, vld && !g);
        chk("rdy1", req1_ready, vld && g);
        chk("hold_y", rsp_y, lasty);
        if (vld) begin
          sbq.push_back(g ? model_alu(1'b1, req1_a, req1_b, req1_op)
                          : model_alu(1'b0, req0_a, req0_b, req0_op));
          grants++;
          mst = 1;
        end
      end else if (mst == 1) begin
        chk("exec_rdy", {req0_ready, req1_ready}, 0);
        chk("exec_y", rsp_y, lasty);
        mst = 2;
      end else begin
        chk("resp_rdy", {req0_ready, req1_ready}, 0);
        chk("sb_depth", sbq.size(), 1);
        if (sbq.size() > 0) begin
          e_cur = sbq[0];
          chk("rsp_y", rsp_y, e_cur.y);
          chk("rsp_id", rsp_id, e_cur.id);
`ifdef ALU_ARBITER_FLAGS_EN
          chk("rsp_carry", rsp_carry, e_cur.c);
          chk("rsp_zero", rsp_zero, e_cur.z);
`endif
          if (rsp_ready) begin
            seen_y  = rsp_y;
            seen_id = rsp_id;
`ifdef ALU_ARBITER_FLAGS_EN
            seen_c  = rsp_carry;
            seen_z  = rsp_zero;
`else
            seen_c  = e_cur.c;
            seen_z  = e_cur.z;
`endif
            ids.push_back(rsp_id);
            lasty = e_cur.y;
            mptr  = !e_cur.id;
            void'(sbq.pop_front());
            served++;
            mst = 0;
          end
        end
      end
    end
  end

  task automatic wait_grants(input string tag, input int target);
    int i;
    for (i = 0; i < 100 && grants < target; i++) @(negedge clk);
    if (grants < target) chk(tag, 0, 1);
  endtask

  task automatic wait_served(input string tag, input int target);
    int i;
    for (i = 0; i < 100 && served < target; i++) @(negedge clk);
    if (served < target) chk(tag, 0, 1);
  endtask

  task automatic set0(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op);
    req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
  endtask

  task automatic set1(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op);
    req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic one0(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op);
    int g0, s0;
    g0 = grants; s0 = served;
    @(posedge clk); #1 set0(a, b, op);
    wait_grants("one0_grant", g0 + 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_served("one0_rsp", s0 + 1);
  endtask

  initial begin
    int g0, s0;
    // Request pending across reset release: accepted on first edge
    set0(4'b1100, 4'b1010, 2'b00);
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    wait_grants("t032_grant", 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_served("t032_rsp", 1);
    chk("t032_y", seen_y, 4'b1000);
    chk("t032_id", seen_id, 0);

    // Simultaneous requests after reset: req0 first, then req1
    do_reset();
    g0 = grants; s0 = served;
    set0(4'b0011, 4'b0101, 2'b10);
    set1(4'b0110, 4'b0011, 2'b11);
    wait_grants("t033_g0", g0 + 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_served("t033_r0", s0 + 1);
    chk("t033_y0", seen_y, 4'b1000);
    chk("t033_id0", seen_id, 0);
    wait_grants("t033_g1", g0 + 2);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_served("t033_r1", s0 + 2);
    chk("t033_y1", seen_y, 4'b0011);
    chk("t033_id1", seen_id, 1);

    // Both held valid: strict alternation starting at req0
    do_reset();
    ids.delete();
    s0 = served;
    set0(4'b1010, 4'b0101, 2'b01);
    set1(4'b1110, 4'b0111, 2'b00);
    wait_served("t034_rsp", s0 + 6);
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("t034_cnt", ids.size() >= 6, 1);
    for (int k = 0; k < 6 && k < ids.size(); k++)
      chk($sformatf("t034_id%0d", k), ids[k], k % 2);

    // Consumer stalls in RESP: outputs held, busy high
    s0 = served; g0 = grants;
    rsp_ready = 1'b0;
    @(posedge clk); #1 set1(4'b0001, 4'b0010, 2'b11);
    wait_grants("t035_grant", g0 + 1);
    @(posedge clk); #1 req1_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("t035_stall", served, s0);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_served("t035_rsp", s0 + 1);
    chk("t035_y", seen_y, 4'b1111);
    chk("t035_id", seen_id, 1);

    // Reset during EXEC: no response, pointer back to req0
    one0(4'b0101, 4'b0011, 2'b10);
    g0 = grants; s0 = served;
    @(posedge clk); #1 set0(4'b0111, 4'b0001, 2'b00);
    wait_grants("t036_grant", g0 + 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t036_noresp", served, s0);
    @(posedge clk); #1;
    set0(4'b1001, 4'b0011, 2'b01);
    set1(4'b1000, 4'b0001, 2'b10);
    wait_grants("t036_g", g0 + 2);
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    wait_served("t036_rsp", s0 + 1);
    chk("t036_id", seen_id, 0);
    chk("t036_y", seen_y, 4'b1011);

`ifdef ALU_ARBITER_FLAGS_EN
    one0(4'b1111, 4'b0001, 2'b10);
    chk("t037_add_y", seen_y, 4'b0000);
    chk("t037_add_c", seen_c, 1);
    chk("t037_add_z", seen_z, 1);
    one0(4'b0001, 4'b0010, 2'b11);
    chk("t037_sub_y", seen_y, 4'b1111);
    chk("t037_sub_c", seen_c, 1);
    chk("t037_sub_z", seen_z, 0);
`endif

    // Random traffic, including valids dropped before ready
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = W'($urandom); req0_b = W'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom);
      req0_op = 2'($urandom); req1_op = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    chk("end_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
